// File: rtl/pe_cfg_pkg.sv
// Shared PE configuration widths, the NOP context word and sequencer state encoding.
package pe_cfg_pkg;

    localparam int unsigned CONFIG_CMAC   = 16;
    localparam int unsigned CONFIG_CORDIC = 8;
    localparam int unsigned CONFIG_LOGI   = 9;
    localparam int unsigned CONFIG_DMEM   = 31;
    localparam int unsigned CONFIG_ALL    = CONFIG_CMAC + CONFIG_CORDIC + CONFIG_LOGI + CONFIG_DMEM;

    // Field layout of one context word, cmac in the top bits.
    typedef struct packed {
        logic [CONFIG_CMAC-1:0]   cmac;
        logic [CONFIG_CORDIC-1:0] cordic;
        logic [CONFIG_LOGI-1:0]   logi;
        logic [CONFIG_DMEM-1:0]   dmem;
    } pe_config_t;

    localparam pe_config_t CONFIG_NOP = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctx_state_e;

endpackage

// File: rtl/pe_ctx_mem.sv
// Context register file: one synchronous write port, one combinational read port.
// Optional per-entry even-parity bit when PE_CTX_PARITY_EN is defined.
module pe_ctx_mem
    import pe_cfg_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [CONFIG_ALL-1:0]    wr_data_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
`ifdef PE_CTX_PARITY_EN
    output logic                     rd_par_ok_c_o,
`endif
    output logic [CONFIG_ALL-1:0]    rd_data_c_o
);

    logic [CONFIG_ALL-1:0] mem_q [DEPTH];

    // Storage is intentionally not reset; entries are undefined until written.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_c_o = mem_q[rd_addr_i];

`ifdef PE_CTX_PARITY_EN
    logic [DEPTH-1:0] par_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            par_q[wr_addr_i] <= ^wr_data_i;
        end
    end

    assign rd_par_ok_c_o = ((^rd_data_c_o) == par_q[rd_addr_i]);
`endif

endmodule

// File: rtl/pe_ctx_seq.sv
// Context sequencer driving the PE config_all bus from a small context memory.
// Optional parity protection of context entries: define PE_CTX_PARITY_EN.
module pe_ctx_seq
    import pe_cfg_pkg::*;
#(
    parameter int unsigned CTX_DEPTH = 16,
    parameter int unsigned LOOP_W    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_wr_en,
    input  logic [$clog2(CTX_DEPTH)-1:0] cfg_wr_addr,
    input  logic [CONFIG_ALL-1:0]        cfg_wr_data,
    input  logic                         start,
    input  logic [$clog2(CTX_DEPTH)-1:0] ctx_last,
    input  logic [LOOP_W-1:0]            loop_cnt,
    input  logic                         halt,
    output logic [CONFIG_ALL-1:0]        config_all,
    output logic                         busy,
    output logic                         done,
`ifdef PE_CTX_PARITY_EN
    output logic                         parity_err,
`endif
    output logic                         cfg_err
);

    localparam int unsigned AW = $clog2(CTX_DEPTH);

    ctx_state_e        state_q, state_d;
    logic [AW-1:0]     pc_q, pc_d;
    logic [AW-1:0]     last_q, last_d;
    logic [LOOP_W-1:0] rem_q, rem_d;
    pe_config_t        cfg_q, cfg_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cfg_err_q, cfg_err_d;

    logic                  mem_we_c;
    logic [CONFIG_ALL-1:0] rd_data_c;
    logic                  issue_ok_c;

    pe_ctx_mem #(
        .DEPTH (CTX_DEPTH)
    ) u_mem (
        .clk           (clk),
        .wr_en_i       (mem_we_c),
        .wr_addr_i     (cfg_wr_addr),
        .wr_data_i     (cfg_wr_data),
        .rd_addr_i     (pc_q),
`ifdef PE_CTX_PARITY_EN
        .rd_par_ok_c_o (issue_ok_c),
`endif
        .rd_data_c_o   (rd_data_c)
    );

`ifndef PE_CTX_PARITY_EN
    assign issue_ok_c = 1'b1;
`endif

    // Writes are only committed while IDLE; anything else is a host error.
    assign mem_we_c = cfg_wr_en && (state_q == IDLE);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        last_d    = last_q;
        rem_d     = rem_q;
        cfg_d     = CONFIG_NOP;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        cfg_err_d = cfg_err_q | (cfg_wr_en && (state_q != IDLE));

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    last_d  = ctx_last;
                    rem_d   = loop_cnt;
                    pc_d    = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy_d = 1'b1;
                // halt leaves cfg_d at NOP and freezes pc/rem for a bubble cycle
                if (!halt) begin
                    if (!issue_ok_c) begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        cfg_d = pe_config_t'(rd_data_c);
                        if (pc_q == last_q) begin
                            if (rem_q == '0) begin
                                state_d = DONE;
                            end else begin
                                pc_d  = '0;
                                rem_d = rem_q - LOOP_W'(1);
                            end
                        end else begin
                            pc_d = pc_q + AW'(1);
                        end
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            last_q    <= '0;
            rem_q     <= '0;
            cfg_q     <= CONFIG_NOP;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            last_q    <= last_d;
            rem_q     <= rem_d;
            cfg_q     <= cfg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
        end
    end

`ifdef PE_CTX_PARITY_EN
    logic parity_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err_q <= 1'b0;
        end else if ((state_q == RUN) && !halt && !issue_ok_c) begin
            parity_err_q <= 1'b1;
        end
    end

    assign parity_err = parity_err_q;
`endif

    assign config_all = cfg_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_pe_ctx_seq.sv
// Directed scoreboard bench for pe_ctx_seq (parity scenario only with PE_CTX_PARITY_EN).
module tb_pe_ctx_seq;
    import pe_cfg_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned LW    = 8;

    typedef struct packed {
        logic [CONFIG_ALL-1:0] cfg;
        logic                  busy;
        logic                  done;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  cfg_wr_en;
    logic [AW-1:0]         cfg_wr_addr;
    logic [CONFIG_ALL-1:0] cfg_wr_data;
    logic                  start;
    logic [AW-1:0]         ctx_last;
    logic [LW-1:0]         loop_cnt;
    logic                  halt;
    logic [CONFIG_ALL-1:0] config_all;
    logic                  busy;
    logic                  done;
    logic                  cfg_err;
`ifdef PE_CTX_PARITY_EN
    logic                  parity_err;
`endif

    int checks = 0;
    int errors = 0;
    int nonnop = 0;
    exp_t exp_q[$];
    logic [CONFIG_ALL-1:0] ref_mem [DEPTH];

    always #5 clk = ~clk;

    pe_ctx_seq #(
        .CTX_DEPTH (DEPTH),
        .LOOP_W    (LW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_wr_en   (cfg_wr_en),
        .cfg_wr_addr (cfg_wr_addr),
        .cfg_wr_data (cfg_wr_data),
        .start       (start),
        .ctx_last    (ctx_last),
        .loop_cnt    (loop_cnt),
        .halt        (halt),
        .config_all  (config_all),
        .busy        (busy),
        .done        (done),
`ifdef PE_CTX_PARITY_EN
        .parity_err  (parity_err),
`endif
        .cfg_err     (cfg_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [CONFIG_ALL-1:0] c, input logic b, input logic d);
        exp_t e;
        e.cfg  = c;
        e.busy = b;
        e.done = d;
        exp_q.push_back(e);
    endtask

    // Advance one cycle and compare the outputs against the oldest expectation.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (config_all !== CONFIG_NOP) nonnop++;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("config_all", 64'(config_all), 64'(e.cfg));
            chk("busy", 64'(busy), 64'(e.busy));
            chk("done", 64'(done), 64'(e.done));
        end
    endtask

    task automatic write(input int addr, input logic [CONFIG_ALL-1:0] data);
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = AW'(addr);
        cfg_wr_data = data;
        ref_mem[addr] = data;
        push(CONFIG_NOP, 1'b0, 1'b0);
        step();
        cfg_wr_en = 1'b0;
    endtask

    // Full sequence with optional halt window and an illegal write+start at issue poke_idx.
    task automatic run(input int last, input int loops, input int halt_idx,
                       input int halt_len, input int poke_idx);
        int n;
        n        = (last + 1) * (loops + 1);
        nonnop   = 0;
        ctx_last = AW'(last);
        loop_cnt = LW'(loops);
        start    = 1'b1;
        push(CONFIG_NOP, 1'b0, 1'b0);
        step();
        start     = 1'b0;
        cfg_wr_en = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (k == halt_idx) begin
                for (int h = 0; h < halt_len; h++) begin
                    halt = 1'b1;
                    push(CONFIG_NOP, 1'b1, 1'b0);
                    step();
                end
            end
            halt = 1'b0;
            if (k == poke_idx) begin
                cfg_wr_en   = 1'b1;
                cfg_wr_addr = AW'(1);
                cfg_wr_data = ~ref_mem[1];
                start       = 1'b1;
            end
            push(ref_mem[k % (last + 1)], 1'b1, 1'b0);
            step();
            cfg_wr_en = 1'b0;
            start     = 1'b0;
        end
        push(CONFIG_NOP, 1'b0, 1'b1);
        step();
        push(CONFIG_NOP, 1'b0, 1'b0);
        step();
    endtask

    initial begin
        logic [CONFIG_ALL-1:0] b0;
        rst         = 1'b1;
        cfg_wr_en   = 1'b0;
        cfg_wr_addr = '0;
        cfg_wr_data = '0;
        start       = 1'b0;
        ctx_last    = '0;
        loop_cnt    = '0;
        halt        = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset config_all", 64'(config_all), 64'(CONFIG_NOP));
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset cfg_err", 64'(cfg_err), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) write(i, {$urandom, $urandom} | 64'h1);
        chk("idle write cfg_err", 64'(cfg_err), 64'd0);

        run(3, 0, -1, 0, -1);
        run(1, 2, -1, 0, -1);
        chk("loop non-NOP count", 64'(nonnop), 64'd6);
        run(3, 0, 2, 2, -1);
        chk("halt non-NOP count", 64'(nonnop), 64'd4);
        run(3, 0, -1, 0, 1);
        chk("cfg_err after run write", 64'(cfg_err), 64'd1);
        run(3, 0, -1, 0, -1);
        chk("cfg_err sticky", 64'(cfg_err), 64'd1);
        run(0, 2, -1, 0, -1);
        chk("ctx_last=0 non-NOP count", 64'(nonnop), 64'd3);

        // Write entry 0 in the same cycle as start; the first issue must see the new data.
        b0          = {$urandom, $urandom} | 64'h1;
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = '0;
        cfg_wr_data = b0;
        ref_mem[0]  = b0;
        run(3, 0, -1, 0, -1);

        // Asynchronous reset while A2 is on the bus.
        ctx_last = AW'(3);
        loop_cnt = '0;
        start    = 1'b1;
        push(CONFIG_NOP, 1'b0, 1'b0);
        step();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push(ref_mem[k], 1'b1, 1'b0);
            step();
        end
        rst = 1'b1;
        #1;
        chk("async rst config_all", 64'(config_all), 64'(CONFIG_NOP));
        chk("async rst busy", 64'(busy), 64'd0);
        chk("async rst cfg_err", 64'(cfg_err), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run(3, 0, -1, 0, -1);

`ifdef PE_CTX_PARITY_EN
        chk("parity_err clear", 64'(parity_err), 64'd0);
        dut.u_mem.par_q[1] = ~dut.u_mem.par_q[1];
        ctx_last = AW'(3);
        start    = 1'b1;
        push(CONFIG_NOP, 1'b0, 1'b0);
        step();
        start = 1'b0;
        push(ref_mem[0], 1'b1, 1'b0);
        step();
        push(CONFIG_NOP, 1'b0, 1'b0);
        step();
        push(CONFIG_NOP, 1'b0, 1'b0);
        step();
        push(CONFIG_NOP, 1'b0, 1'b0);
        step();
        chk("parity_err set", 64'(parity_err), 64'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_ctx_seq.md
Name: pe_ctx_seq

Overview:
- Context sequencer that sits directly upstream of the PE functional-unit cluster and drives its 64-bit `config_all` bus every cycle.
- Holds a small context memory of full FU configurations, loaded through a write port.
- On `start`, it steps through contexts `0..ctx_last` and repeats the sequence `loop_cnt+1` times, then returns to idle and drives a NOP configuration.
- Gives the PE cycle-by-cycle reconfiguration without the host touching `config_all`.

Parameters:
- CONFIG_ALL, 64, width of one context word (cmac 16 + cordic 8 + logical 9 + dmem 31).
- CTX_DEPTH, 16, number of context entries; must be a power of two and at least 2.
- LOOP_W, 8, width of the loop-repeat counter.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- cfg_wr_en  in  1  context write strobe.
- cfg_wr_addr  in  $clog2(CTX_DEPTH)  context write address.
- cfg_wr_data  in  CONFIG_ALL  context write data.
- start  in  1  begin sequence; sampled only in IDLE.
- ctx_last  in  $clog2(CTX_DEPTH)  last context index of the sequence; sampled at start.
- loop_cnt  in  LOOP_W  extra repetitions; sampled at start (0 = run once).
- halt  in  1  stall request during RUN.
- config_all  out  CONFIG_ALL  registered configuration to the FU cluster.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse after the final context has been issued.
- cfg_err  out  1  sticky; set by a write attempted during RUN; cleared only by rst.

Behaviour:
- Reset values: every output is 0; `config_all` equals CONFIG_NOP (all zeros). The pc, loop counter and FSM are in IDLE. Context memory contents are not reset (undefined until written).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - A write with `cfg_wr_en` updates entry `cfg_wr_addr` at the clock edge.
  - When `start`=1: capture `ctx_last` into `last_q` and `loop_cnt` into `rem_q`, set pc=0, go to RUN.
  - `config_all` holds CONFIG_NOP.
- RUN, with `halt`=0:
  - Next `config_all` = mem[pc]; registered, so the value appears one cycle after pc selects it.
  - Latency: `start` sampled at edge t → `config_all` = mem[0] during cycle t+1.
  - If pc==last_q and rem_q==0: go to DONE.
  - Otherwise, if pc==last_q: set pc=0 and decrement rem_q (wrap).
  - Otherwise: pc++.
  - `busy`=1.
- RUN, with `halt`=1:
  - pc and rem_q are frozen.
  - Next `config_all` = CONFIG_NOP, a bubble so that FIFO and memory enables are dropped.
  - Deasserting `halt` resumes at the same pc with no context skipped or repeated.
- DONE:
  - `config_all` = CONFIG_NOP, `done`=1 for exactly one cycle, `busy`=0, then go to IDLE.
- Total issued contexts = (last_q+1)·(rem_q+1); for example ctx_last=3, loop_cnt=2 issues 12 contexts.
- `ctx_last`=0 is legal: context 0 is issued repeatedly.
- A `start` in RUN or DONE is ignored.
- A `cfg_wr_en` in RUN or DONE is dropped, memory is unchanged, and `cfg_err` is set.
- In IDLE, a simultaneous write and `start` is allowed: the write is committed and the sequence starts. If the write targets entry 0, mem[0] read at t+1 returns the new data.
- Reset asserted mid-RUN: asynchronous return to IDLE, `config_all` becomes CONFIG_NOP immediately, and `cfg_err` is cleared.

Optional Feature:
- Macro: `PE_CTX_PARITY_EN`.
- When defined:
  - Each entry stores an extra even-parity bit computed on write.
  - On issue, a parity mismatch drives CONFIG_NOP instead of the entry, sets a sticky output `parity_err` (extra 1-bit port, reset 0) and aborts to IDLE without a `done` pulse.
- When undefined:
  - No parity storage and no `parity_err` port.
  - Behaviour is exactly as above.

Decomposition:
- Package `pe_cfg_pkg` holds:
  - CONFIG_CMAC=16, CONFIG_CORDIC=8, CONFIG_LOGI=9, CONFIG_DMEM=31, and CONFIG_ALL as their sum.
  - CONFIG_NOP constant.
  - Sequencer state enum `ctx_state_e` {IDLE, RUN, DONE}.
- One sub-module, `pe_ctx_mem`: register-file storage with 1 synchronous write port and 1 combinational read port, plus the optional parity bit. The FSM, counters and output register stay in `pe_ctx_seq`.

Test Plan:
- Write mem[0..3]=A0..A3, start with ctx_last=3 and loop_cnt=0 → `config_all` is A0,A1,A2,A3 on cycles t+1..t+4; `done` pulses at t+5 with NOP; `busy` is high for cycles t+1..t+4.
- ctx_last=1, loop_cnt=2 → sequence A0,A1,A0,A1,A0,A1, then `done`; exactly 6 non-NOP cycles.
- `halt` high for 2 cycles while pc=2 → A0,A1,NOP,NOP,A2,A3; no skip or duplicate.
- `cfg_wr_en` to address 1 during RUN → mem[1] unchanged on the next run and `cfg_err`=1 until rst; `start` during RUN has no effect.
- Assert rst while A2 is on the bus → `config_all`=0 and `busy`=0 asynchronously; after release, a new start reissues from A0.
- With `PE_CTX_PARITY_EN` and a corrupted entry 1 (forced bit flip) → A0, then NOP; `parity_err`=1; FSM in IDLE; no `done` pulse.
